// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates two level-held display requesters and holds the
// granted display mode for HOLD_CYCLES clock cycles before returning to idle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req_a/data_a requester A request (level, held until gnt_a) and value
//   req_b/data_b requester B request (level, held until gnt_b) and value
//   skip         ends the current hold early (ignored in idle)
//   state        display mode: 00 idle, 01 show A, 10 show B, 11 show both
//   ret22/ret33  registered captured values for A / B
//   gnt_a/gnt_b  one-cycle capture pulses, first cycle of a show state only
//   busy         high whenever state != 00
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  input  logic        skip,
  output logic [1:0]  state,
  output logic [31:0] ret22,
  output logic [31:0] ret33,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy
);

  // Encoding matches the state output directly: bit 0 = A shown, bit 1 = B shown.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShowA  = 2'b01,
    StShowB  = 2'b10,
    StShowAb = 2'b11
  } state_e;

  localparam logic [15:0] HoldLoad = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] ret22_q, ret22_d;
  logic [31:0] ret33_q, ret33_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret22_d = ret22_q;
    ret33_d = ret33_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    case (state_q)
      StIdle: begin
        // Requests are only sampled here; anything raised during a hold waits.
        if (req_a || req_b) begin
          state_d = state_e'({req_b, req_a});
          cnt_d   = HoldLoad;
          if (req_a) begin
            ret22_d = data_a;
            gnt_a_d = 1'b1;
          end
          if (req_b) begin
            ret33_d = data_b;
            gnt_b_d = 1'b1;
          end
        end
      end
      default: begin
        // Exit always passes through idle, so 00 is visible for at least a cycle.
        if (skip || (cnt_q == 16'd0)) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      ret22_q <= 32'd0;
      ret33_q <= 32'd0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret22_q <= ret22_d;
      ret33_q <= ret33_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  assign state = state_q;
  assign ret22 = ret22_q;
  assign ret33 = ret33_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: table of directed vectors on a HOLD_CYCLES=4
// instance, plus hand-written sequences for mid-hold reset and HOLD_CYCLES=1.
module tb_display_scheduler;

  logic        clk;
  logic        rst;
  logic        req_a, req_b, skip;
  logic [31:0] data_a, data_b;
  logic [1:0]  state;
  logic [31:0] ret22, ret33;
  logic        gnt_a, gnt_b, busy;

  logic        req_a1, req_b1, skip1;
  logic [31:0] data_a1, data_b1;
  logic [1:0]  state1;
  logic [31:0] ret22_1, ret33_1;
  logic        gnt_a1, gnt_b1, busy1;

  int checks = 0;
  int errors = 0;

  display_scheduler #(.HOLD_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b),
    .data_b(data_b), .skip(skip), .state(state), .ret22(ret22), .ret33(ret33),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy)
  );

  display_scheduler #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_a(req_a1), .data_a(data_a1), .req_b(req_b1),
    .data_b(data_b1), .skip(skip1), .state(state1), .ret22(ret22_1), .ret33(ret33_1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        req_a;
    logic        req_b;
    logic        skip;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [1:0]  st;
    logic        ga;
    logic        gb;
    logic [31:0] r22;
    logic [31:0] r33;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ra, logic rb, logic sk, logic [31:0] da, logic [31:0] db,
                              logic [1:0] st, logic ga, logic gb, logic [31:0] r22,
                              logic [31:0] r33);
    vec_t v;
    v.req_a = ra; v.req_b = rb; v.skip = sk; v.data_a = da; v.data_b = db;
    v.st = st; v.ga = ga; v.gb = gb; v.r22 = r22; v.r33 = r33;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic ga,
                           input logic gb, input logic [31:0] r22, input logic [31:0] r33);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".gnt_a"}, 32'(gnt_a), 32'(ga));
    check({tag, ".gnt_b"}, 32'(gnt_b), 32'(gb));
    check({tag, ".ret22"}, ret22, r22);
    check({tag, ".ret33"}, ret33, r33);
    check({tag, ".busy"}, 32'(busy), 32'(st != 2'b00));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DA = 32'd124812789;
  localparam logic [31:0] DB = 32'd12828;

  initial begin
    rst = 1'b1;
    req_a = 0; req_b = 0; skip = 0; data_a = 0; data_b = 0;
    req_a1 = 0; req_b1 = 0; skip1 = 0; data_a1 = 0; data_b1 = 0;

    // Single A, 4-cycle hold
    vq.push_back(mk(1, 0, 0, DA, 0, 2'b01, 1, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, DA, 0));
    // Simultaneous A and B
    vq.push_back(mk(1, 1, 0, 32'd5, DB, 2'b11, 1, 1, 32'd5, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 32'd5, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 32'd5, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 32'd5, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 32'd5, DB));
    // B raised during SHOW_A stays pending
    vq.push_back(mk(1, 0, 0, 32'd77, 0, 2'b01, 1, 0, 32'd77, DB));
    vq.push_back(mk(0, 1, 0, 0, 32'd999, 2'b01, 0, 0, 32'd77, DB));
    vq.push_back(mk(0, 1, 0, 0, 32'd999, 2'b01, 0, 0, 32'd77, DB));
    vq.push_back(mk(0, 1, 0, 0, 32'd999, 2'b01, 0, 0, 32'd77, DB));
    vq.push_back(mk(0, 1, 0, 0, 32'd999, 2'b00, 0, 0, 32'd77, DB));
    vq.push_back(mk(0, 1, 0, 0, 32'd999, 2'b10, 0, 1, 32'd77, 32'd999));
    // Skip in 2nd cycle of SHOW_B
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 32'd77, 32'd999));
    vq.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 32'd77, 32'd999));
    // Skip ignored in idle, with and without a request
    vq.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 32'd77, 32'd999));
    vq.push_back(mk(1, 0, 1, 32'd31, 0, 2'b01, 1, 0, 32'd31, 32'd999));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 32'd31, 32'd999));
    vq.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 32'd31, 32'd999));

    // Reset state, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    check_all("reset", 2'b00, 0, 0, 0, 0);
    check("reset.state1", 32'(state1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      req_a = vq[i].req_a; req_b = vq[i].req_b; skip = vq[i].skip;
      data_a = vq[i].data_a; data_b = vq[i].data_b;
      step();
      check_all($sformatf("row%0d", i), vq[i].st, vq[i].ga, vq[i].gb, vq[i].r22, vq[i].r33);
    end

    // Reset in the 3rd hold cycle, req_a held throughout
    req_a = 1; req_b = 0; skip = 0; data_a = 32'd555; data_b = 0;
    step();
    check_all("rh.grant", 2'b01, 1, 0, 32'd555, 32'd999);
    step();
    step();
    check_all("rh.cyc3", 2'b01, 0, 0, 32'd555, 32'd999);
    #3 rst = 1'b0;
    #1;
    check_all("rh.async", 2'b00, 0, 0, 0, 0);
    step();
    check_all("rh.held", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_all("rh.regrant", 2'b01, 1, 0, 32'd555, 0);
    req_a = 0;
    step();
    check_all("rh.after", 2'b01, 0, 0, 32'd555, 0);

    // HOLD_CYCLES=1 with req_a held high: 01,00,01,00...
    req_a1 = 1; data_a1 = 32'hABCD_0123;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("h1.%0d.state", i), 32'(state1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("h1.%0d.gnt_a", i), 32'(gnt_a1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("h1.%0d.ret22", i), ret22_1, 32'hABCD_0123);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
